// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam int WORD_W      = 32;
   localparam int LANES       = 4;
   localparam int DEF_DEPTH   = 256;
   localparam int DEF_LATENCY = 2;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with per-lane writes and a registered read port
module dmem_array import dmem_pkg::*; #(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic [LANES-1:0]  we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH];
   // lane-masked write and read-enabled word capture; contents survive reset
   always_ff @(posedge clock) begin
      for (int i = 0; i < LANES; i++)
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with fixed latency
module dmem_responder import dmem_pkg::*; #(
   parameter int DEPTH_WORDS = DEF_DEPTH,
   parameter int LATENCY     = DEF_LATENCY
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);
   localparam int AW = $clog2(DEPTH_WORDS);
   state_t      state, state_n;
   logic [2:0]  cnt;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_write, cap_err;
   logic        accept, go;
   logic [31:0] cur_addr, cur_wdata;
   logic [3:0]  cur_be;
   logic        cur_write, cur_err;
   logic [LANES-1:0]  we;
   logic [WORD_W-1:0] arr_rdata;
   assign req_ready = (state == IDLE) & ~reset;
   assign accept    = req_valid & req_ready;
   // with LATENCY=1 memory is touched on the accept edge, so use live inputs in IDLE
   assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
   assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;
   assign cur_be    = (state == IDLE) ? req_be    : cap_be;
   assign cur_write = (state == IDLE) ? req_write : cap_write;
   assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
   assign we        = cur_be & {LANES{go & cur_write & ~cur_err}};
   assign rsp_valid = (state == RESP);
   assign rsp_error = (state == RESP) & cap_err;
   assign rsp_rdata = (state == RESP && !cap_write && !cap_err) ? arr_rdata : 32'h0;
   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   // next state and the memory-commit strobe (go marks the edge entering RESP)
   always_comb begin
      state_n = state;
      go      = 1'b0;
      if (state == IDLE && accept) begin
         state_n = (LATENCY > 1) ? WAIT : RESP;
         go      = (LATENCY == 1);
      end else if (state == WAIT && cnt == 3'd0) begin
         state_n = RESP;
         go      = ~reset;
      end else if (state == RESP && rsp_ready) begin
         state_n = IDLE;
      end
   end
   // latency countdown for the WAIT state
   always_ff @(posedge clock) begin
      if (reset) cnt <= 3'd0;
      else if (accept) cnt <= 3'((LATENCY > 1) ? LATENCY - 2 : 0);
      else if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
   end
   // request capture on the accept edge
   always_ff @(posedge clock) begin
      if (accept) begin
         cap_addr  <= req_addr;
         cap_wdata <= req_wdata;
         cap_be    <= req_be;
         cap_write <= req_write;
         cap_err   <= cur_err;
      end
   end
   dmem_array #(.DEPTH(DEPTH_WORDS)) u_array (
      .clock (clock),
      .we    (we),
      .re    (go),
      .addr  (cur_addr[AW+1:2]),
      .wdata (cur_wdata),
      .rdata (arr_rdata)
   );
endmodule
